pic16f84_cycle_ctrl: RTL

PIC16F84_CYCLE_CTRL -- requirements
Module: pic16f84_cycle_ctrl

---
 rtl/pic16f84_pkg.sv | 49 ++++
 rtl/pic16f84_ost_timer.sv | 29 ++
 rtl/pic16f84_cycle_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pic16f84_pkg.sv
// Shared definitions for the PIC16F84 instruction-cycle controller:
// controller states, Q-phase index and the NOP-cycle flag values.
package pic16f84_pkg;

   typedef enum logic [1:0] {
      ST_OST   = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_SLEEP = 2'd3
   } cycle_state_t;

   typedef enum logic [1:0] {
      PH_Q1 = 2'd0,
      PH_Q2 = 2'd1,
      PH_Q3 = 2'd2,
      PH_Q4 = 2'd3
   } phase_t;

   // Value of exec_valid for a forced-NOP cycle and for a real instruction.
   localparam logic NOP_CYCLE  = 1'b0;
   localparam logic REAL_CYCLE = 1'b1;

   // Phase index to one-hot {q1, q2, q3, q4}.
   function automatic logic [3:0] phase_onehot(input phase_t p);
      logic [3:0] oh;
      oh = 4'b0000;
      unique case (p)
         PH_Q1: oh = 4'b1000;
         PH_Q2: oh = 4'b0100;
         PH_Q3: oh = 4'b0010;
         PH_Q4: oh = 4'b0001;
      endcase
      return oh;
   endfunction

   // Q1 -> Q2 -> Q3 -> Q4 -> Q1.
   function automatic phase_t next_phase(input phase_t p);
      phase_t n;
      n = PH_Q1;
      unique case (p)
         PH_Q1: n = PH_Q2;
         PH_Q2: n = PH_Q3;
         PH_Q3: n = PH_Q4;
         PH_Q4: n = PH_Q1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pic16f84_ost_timer.sv
// Oscillator start-up timer: counts clk edges while start is held and
// raises done once OST_CYCLES edges have been seen. Dropping start clears it.
module pic16f84_ost_timer #(
   parameter int OST_CYCLES = 16
) (
   input  logic clk,
   input  logic mclr,
   input  logic start,
   output logic done
);

   localparam int CW = $clog2(OST_CYCLES + 1);

   logic [CW-1:0] count;

   assign done = (count == CW'(OST_CYCLES));

   // Edge counter, saturating at OST_CYCLES, cleared whenever start is low.
   always_ff @(posedge clk or negedge mclr) begin
      if (!mclr) begin
         count <= '0;
      end else if (!start) begin
         count <= '0;
      end else if (!done) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/pic16f84_cycle_ctrl.sv
// PIC16F84 instruction-cycle controller: start-up hold, Q1-Q4 phase
// generation, branch flush and SLEEP/wake sequencing. Every output is a flop.
module pic16f84_cycle_ctrl
   import pic16f84_pkg::*;
#(
   parameter int OST_CYCLES = 16
) (
   input  logic clk,
   input  logic mclr,
   input  logic branch_taken,
   input  logic sleep_req,
   input  logic wake,
   output logic q1,
   output logic q2,
   output logic q3,
   output logic q4,
   output logic clk_out,
   output logic pc_inc,
   output logic ir_load,
   output logic exec_valid,
   output logic sleeping,
   output logic ready
);

   cycle_state_t state, state_d;
   phase_t       phase, phase_d;
   logic         warm, warm_d;     // set once the core has slept; a wake resumes with a prefetched instruction
   logic         exec_d;
   logic         ost_done;
   logic         run_d;
   logic [3:0]   q_d;

   pic16f84_ost_timer #(.OST_CYCLES(OST_CYCLES)) u_ost (
      .clk   (clk),
      .mclr  (mclr),
      .start (state == ST_OST),
      .done  (ost_done)
   );

   // Next state, next phase and the registered output values.
   always_comb begin
      state_d = state;
      phase_d = phase;
      exec_d  = exec_valid;
      warm_d  = warm;
      unique case (state)
         ST_OST: begin
            if (ost_done) begin
               state_d = ST_RUN;
               phase_d = PH_Q1;
               exec_d  = warm ? REAL_CYCLE : NOP_CYCLE;
            end
         end
         ST_RUN, ST_FLUSH: begin
            phase_d = next_phase(phase);
            if (phase == PH_Q4) begin
               state_d = ST_RUN;
               exec_d  = REAL_CYCLE;
               if (exec_valid == REAL_CYCLE) begin
                  if (sleep_req && !wake) begin
                     state_d = ST_SLEEP;
                     exec_d  = NOP_CYCLE;
                     warm_d  = 1'b1;
                  end else if (sleep_req) begin
                     state_d = ST_RUN;   // SLEEP with a pending wake runs as a NOP
                  end else if (branch_taken) begin
                     state_d = ST_FLUSH;
                     exec_d  = NOP_CYCLE;
                  end
               end
            end
         end
         ST_SLEEP: begin
            if (wake) begin
               state_d = ST_OST;
            end
         end
      endcase
      run_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
      q_d   = run_d ? phase_onehot(phase_d) : 4'b0000;
   end

   // State and output registers; mclr clears everything immediately.
   always_ff @(posedge clk or negedge mclr) begin
      if (!mclr) begin
         state      <= ST_OST;
         phase      <= PH_Q1;
         warm       <= 1'b0;
         q1         <= 1'b0;
         q2         <= 1'b0;
         q3         <= 1'b0;
         q4         <= 1'b0;
         clk_out    <= 1'b0;
         pc_inc     <= 1'b0;
         ir_load    <= 1'b0;
         exec_valid <= 1'b0;
         sleeping   <= 1'b0;
         ready      <= 1'b0;
      end else begin
         state      <= state_d;
         phase      <= phase_d;
         warm       <= warm_d;
         q1         <= q_d[3];
         q2         <= q_d[2];
         q3         <= q_d[1];
         q4         <= q_d[0];
         clk_out    <= q_d[3] | q_d[2];
         pc_inc     <= q_d[3];
         ir_load    <= q_d[0];
         exec_valid <= exec_d;
         sleeping   <= (state_d == ST_SLEEP);
         ready      <= run_d;
      end
   end

endmodule
